instr_cache: RTL and testbench

- Direct-mapped, read-only instruction cache directly upstream of the instruction-fetch stage.
- Serves 16-bit instruction words for a 16-bit word-addressed PC.
- Produces the instruction and hit flag that fetch forwards into the IF/ID register.
- On a miss, stalls fetch and refills one whole line from instruction memory through a per-beat valid handshake.

---
 rtl/instr_cache_pkg.sv | 30 +++
 rtl/icache_array.sv | 54 +++++
 rtl/instr_cache.sv | 119 +++++++++++
 tb/tb_instr_cache.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_cache_pkg.sv
// rtl/instr_cache_pkg.sv - shared parameters, FSM encoding and address-field helpers for instr_cache
package instr_cache_pkg;

    localparam int ADDR_W         = 16;
    localparam int DATA_W         = 16;
    localparam int LINES          = 16;
    localparam int WORDS_PER_LINE = 4;

    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] addr);
        return addr[OFF_W +: IDX_W];
    endfunction

    function automatic logic [OFF_W-1:0] addr_off(input logic [ADDR_W-1:0] addr);
        return addr[OFF_W-1:0];
    endfunction

endpackage

// File: rtl/icache_array.sv
// rtl/icache_array.sv - valid/tag/data storage for instr_cache with combinational read
module icache_array
    import instr_cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              inv_all,
    input  logic              word_we,
    input  logic [IDX_W-1:0]  word_idx,
    input  logic [OFF_W-1:0]  word_off,
    input  logic [DATA_W-1:0] word_data,
    input  logic              line_we,
    input  logic [IDX_W-1:0]  line_idx,
    input  logic [TAG_W-1:0]  line_tag,
    input  logic              line_valid,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [OFF_W-1:0]  rd_off,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [DATA_W-1:0] rd_data
);

    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [LINES*WORDS_PER_LINE];

    // Global invalidate wins over a simultaneous line install.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (inv_all) begin
            valid <= '0;
        end else if (line_we) begin
            valid[line_idx] <= line_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_mem[line_idx] <= line_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (word_we) begin
            data_mem[{word_idx, word_off}] <= word_data;
        end
    end

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data  = data_mem[{rd_idx, rd_off}];

endmodule

// File: rtl/instr_cache.sv
// rtl/instr_cache.sv - direct-mapped read-only instruction cache with per-beat line refill
module instr_cache
    import instr_cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              flush,
    output logic [DATA_W-1:0] instr_out,
    output logic              hit_out,
    output logic              stall_out,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid
);

    state_t            state, state_nxt;
    logic [OFF_W-1:0]  beat;
    logic [TAG_W-1:0]  miss_tag;
    logic [IDX_W-1:0]  miss_idx;
    logic              flush_pending;

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [OFF_W-1:0]  req_off;
    logic              arr_valid;
    logic [TAG_W-1:0]  arr_tag;
    logic [DATA_W-1:0] arr_data;
    logic              beat_done;
    logic              line_done;
    logic              miss;

    assign req_tag = addr_tag(cpu_addr);
    assign req_idx = addr_idx(cpu_addr);
    assign req_off = addr_off(cpu_addr);

    // Stray responses in IDLE never reach the arrays or the beat counter.
    assign beat_done = (state == REFILL) && mem_rvalid;
    assign line_done = beat_done && (beat == OFF_W'(WORDS_PER_LINE - 1));
    assign miss      = cpu_req && !hit_out;

    icache_array u_array (
        .clk        (clk),
        .rst        (rst),
        .inv_all    ((flush && state == IDLE) || (line_done && (flush_pending || flush))),
        .word_we    (beat_done),
        .word_idx   (miss_idx),
        .word_off   (beat),
        .word_data  (mem_rdata),
        .line_we    (line_done),
        .line_idx   (miss_idx),
        .line_tag   (miss_tag),
        .line_valid (!(flush_pending || flush)),
        .rd_idx     (req_idx),
        .rd_off     (req_off),
        .rd_valid   (arr_valid),
        .rd_tag     (arr_tag),
        .rd_data    (arr_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (miss)      state_nxt = REFILL;
            REFILL:  if (line_done) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        hit_out   = cpu_req && arr_valid && (arr_tag == req_tag) && (state == IDLE);
        instr_out = hit_out ? arr_data : '0;
        stall_out = cpu_req && !hit_out;
        mem_req   = (state == REFILL);
        mem_addr  = mem_req ? {miss_tag, miss_idx, beat} : '0;
    end

    // Beat counter wraps to zero on its own when the last beat lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat          <= '0;
            miss_tag      <= '0;
            miss_idx      <= '0;
            flush_pending <= 1'b0;
        end else if (state == IDLE) begin
            flush_pending <= 1'b0;
            if (miss) begin
                miss_tag <= req_tag;
                miss_idx <= req_idx;
                beat     <= '0;
            end
        end else begin
            if (beat_done) begin
                beat <= beat + 1'b1;
            end
            if (line_done) begin
                flush_pending <= 1'b0;
            end else if (flush) begin
                flush_pending <= 1'b1;
            end
        end
    end

    cpu_addr_held_during_refill: assert property (
        @(posedge clk) disable iff (rst)
        (state == REFILL && cpu_req) |-> (req_tag == miss_tag && req_idx == miss_idx)
    );

endmodule

// File: tb/tb_instr_cache.sv
// tb/tb_instr_cache.sv - randomized self-checking bench for instr_cache against a line-level model
module tb_instr_cache;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic        flush = 1'b0;
    logic [15:0] instr_out;
    logic        hit_out;
    logic        stall_out;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata = '0;
    logic        mem_rvalid = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [15:0] mem_base;
    bit          m_valid [16];
    logic [9:0]  m_tag   [16];
    logic [15:0] m_data  [64];
    logic [15:0] beat_q  [$];

    instr_cache dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .flush      (flush),
        .instr_out  (instr_out),
        .hit_out    (hit_out),
        .stall_out  (stall_out),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mv(input logic [15:0] a);
        return mem_base + a;
    endfunction

    function automatic bit m_hit(input logic [15:0] a);
        return m_valid[a[5:2]] && (m_tag[a[5:2]] == a[15:6]);
    endfunction

    function automatic void m_fill(input logic [15:0] a);
        m_valid[a[5:2]] = 1'b1;
        m_tag[a[5:2]]   = a[15:6];
        for (int w = 0; w < 4; w++) begin
            m_data[{a[5:2], 2'(w)}] = mv({a[15:2], 2'(w)});
        end
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endfunction

    // Holds the request until it hits, acting as a memory with fixed per-beat latency.
    task automatic fetch(input logic [15:0] addr, input int lat, input bit flush_mid,
                         output int stalls, output logic [15:0] data, output bit ok);
        int cnt;
        bit flushed;
        stalls = 0;
        cnt = 0;
        flushed = 1'b0;
        ok = 1'b0;
        data = '0;
        beat_q.delete();
        for (int c = 0; c < 400 && !ok; c++) begin
            @(negedge clk);
            cpu_req = 1'b1;
            cpu_addr = addr;
            mem_rvalid = 1'b0;
            flush = 1'b0;
            #1;
            if (stall_out) stalls++;
            if (hit_out) begin
                ok = 1'b1;
                data = instr_out;
            end else if (mem_req) begin
                cnt++;
                if (flush_mid && !flushed && mem_addr[1:0] == 2'd1) begin
                    flush = 1'b1;
                    flushed = 1'b1;
                end
                if (cnt == lat) begin
                    mem_rvalid = 1'b1;
                    mem_rdata = mv(mem_addr);
                    beat_q.push_back(mem_addr);
                    cnt = 0;
                end
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (hit_out !== 1'b0 || instr_out !== 16'h0) begin
            errors++;
            $display("FAIL reset_hit: hit=%b instr=%h expected 0/0000", hit_out, instr_out);
        end
        checks++;
        if (mem_req !== 1'b0 || mem_addr !== 16'h0) begin
            errors++;
            $display("FAIL reset_mem: req=%b addr=%h expected 0/0000", mem_req, mem_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (stall_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall: got %b expected 0", stall_out);
        end
        m_clear();
    endtask

    task automatic test_cold_miss();
        int st; logic [15:0] d; bit ok;
        mem_base = 16'hA000;
        fetch(16'h0041, 2, 1'b0, st, d, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL cold_timeout: no hit within bound");
        end
        checks++;
        if (st != 9) begin
            errors++;
            $display("FAIL cold_stalls: got %0d expected 9", st);
        end
        checks++;
        if (d !== 16'hA041) begin
            errors++;
            $display("FAIL cold_data: got %h expected a041", d);
        end
        checks++;
        if (beat_q.size() != 4) begin
            errors++;
            $display("FAIL cold_beats: got %0d expected 4", beat_q.size());
        end
        for (int i = 0; i < beat_q.size() && i < 4; i++) begin
            checks++;
            if (beat_q[i] !== 16'h0040 + 16'(i)) begin
                errors++;
                $display("FAIL cold_addr%0d: got %h expected %h", i, beat_q[i], 16'h0040 + 16'(i));
            end
        end
        m_fill(16'h0041);
    endtask

    task automatic test_seq_hits();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cpu_req = 1'b1;
            cpu_addr = 16'h0040 + 16'(i);
            mem_rvalid = 1'b0;
            #1;
            checks++;
            if (hit_out !== 1'b1 || instr_out !== 16'hA040 + 16'(i) || mem_req !== 1'b0) begin
                errors++;
                $display("FAIL seq_hit%0d: hit=%b instr=%h req=%b expected 1/%h/0",
                         i, hit_out, instr_out, mem_req, 16'hA040 + 16'(i));
            end
        end
    endtask

    task automatic test_conflict();
        int st; logic [15:0] d; bit ok;
        fetch(16'h0440, 1, 1'b0, st, d, ok);
        checks++;
        if (!ok || st != 5 || d !== 16'hA440) begin
            errors++;
            $display("FAIL conflict_fill: ok=%b stalls=%0d data=%h expected 1/5/a440", ok, st, d);
        end
        checks++;
        if (beat_q.size() == 0 || beat_q[0] !== 16'h0440) begin
            errors++;
            $display("FAIL conflict_addr: first beat %h expected 0440",
                     beat_q.size() ? beat_q[0] : 16'hxxxx);
        end
        m_fill(16'h0440);
        fetch(16'h0040, 1, 1'b0, st, d, ok);
        checks++;
        if (!ok || st != 5 || d !== 16'hA040) begin
            errors++;
            $display("FAIL conflict_evict: ok=%b stalls=%0d data=%h expected 1/5/a040", ok, st, d);
        end
        m_fill(16'h0040);
    endtask

    task automatic test_flush_idle();
        @(negedge clk);
        cpu_req = 1'b1;
        cpu_addr = 16'h0042;
        flush = 1'b1;
        #1;
        checks++;
        if (hit_out !== 1'b1 || instr_out !== 16'hA042) begin
            errors++;
            $display("FAIL flush_idle_hit: hit=%b instr=%h expected 1/a042", hit_out, instr_out);
        end
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++;
        if (hit_out !== 1'b0 || instr_out !== 16'h0 || stall_out !== 1'b1) begin
            errors++;
            $display("FAIL flush_idle_after: hit=%b instr=%h stall=%b expected 0/0000/1",
                     hit_out, instr_out, stall_out);
        end
        cpu_req = 1'b0;
        m_clear();
    endtask

    task automatic test_flush_refill();
        int st; logic [15:0] d; bit ok;
        mem_base = 16'hB000;
        fetch(16'h00C4, 1, 1'b0, st, d, ok);
        m_fill(16'h00C4);
        fetch(16'h0080, 1, 1'b1, st, d, ok);
        checks++;
        if (!ok || st != 10 || d !== 16'hB080) begin
            errors++;
            $display("FAIL flush_refill: ok=%b stalls=%0d data=%h expected 1/10/b080", ok, st, d);
        end
        checks++;
        if (beat_q.size() != 8) begin
            errors++;
            $display("FAIL flush_refill_beats: got %0d expected 8", beat_q.size());
        end
        m_clear();
        m_fill(16'h0080);
        fetch(16'h00C4, 1, 1'b0, st, d, ok);
        checks++;
        if (!ok || st != 5 || d !== 16'hB0C4) begin
            errors++;
            $display("FAIL flush_refill_other: ok=%b stalls=%0d data=%h expected 1/5/b0c4", ok, st, d);
        end
        m_fill(16'h00C4);
    endtask

    task automatic test_reset_mid_refill();
        int st; logic [15:0] d; bit ok;
        mem_base = 16'hC000;
        @(negedge clk);
        cpu_req = 1'b1;
        cpu_addr = 16'h0108;
        @(negedge clk);
        #1;
        mem_rvalid = 1'b1;
        mem_rdata = mv(16'h0108);
        @(negedge clk);
        #1;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0109) begin
            errors++;
            $display("FAIL rst_mid_beat1: req=%b addr=%h expected 1/0109", mem_req, mem_addr);
        end
        mem_rdata = mv(16'h0109);
        @(negedge clk);
        mem_rvalid = 1'b0;
        cpu_req = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0 || mem_addr !== 16'h0) begin
            errors++;
            $display("FAIL rst_mid_req: req=%b addr=%h expected 0/0000", mem_req, mem_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata = 16'hFFFF;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_late: req=%b expected 0", mem_req);
        end
        @(negedge clk);
        mem_rvalid = 1'b0;
        m_clear();
        fetch(16'h0108, 1, 1'b0, st, d, ok);
        checks++;
        if (!ok || st != 5 || d !== 16'hC108) begin
            errors++;
            $display("FAIL rst_mid_refetch: ok=%b stalls=%0d data=%h expected 1/5/c108", ok, st, d);
        end
        checks++;
        if (beat_q.size() == 0 || beat_q[0] !== 16'h0108) begin
            errors++;
            $display("FAIL rst_mid_beat0: first beat %h expected 0108",
                     beat_q.size() ? beat_q[0] : 16'hxxxx);
        end
        m_fill(16'h0108);
    endtask

    task automatic test_stray();
        int st; logic [15:0] d; bit ok;
        logic [15:0] a;
        mem_base = 16'($urandom);
        for (int i = 0; i < 16; i++) begin
            a = {10'($urandom), 4'(i), 2'($urandom)};
            fetch(a, 1, 1'b0, st, d, ok);
            if (st != 0) m_fill(a);
        end
        repeat (4) begin
            @(negedge clk);
            cpu_req = 1'b0;
            mem_rvalid = 1'b1;
            mem_rdata = 16'hFFFF;
        end
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            cpu_req = 1'b1;
            cpu_addr = {m_tag[i/4], 6'(i)};
            #1;
            checks++;
            if (hit_out !== 1'b1 || instr_out !== m_data[i]) begin
                errors++;
                $display("FAIL stray_word%0d: hit=%b instr=%h expected 1/%h",
                         i, hit_out, instr_out, m_data[i]);
            end
        end
    endtask

    task automatic test_random();
        int st; logic [15:0] d; bit ok;
        logic [15:0] a, exp_d;
        bit exp_hit;
        int lat;
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                @(negedge clk);
                cpu_req = 1'b0;
                mem_rvalid = 1'b0;
                flush = 1'b1;
                m_clear();
            end
            if ($urandom_range(0, 5) == 0) mem_base = 16'($urandom);
            a = {10'($urandom_range(0, 3)), 4'($urandom), 2'($urandom)};
            lat = $urandom_range(1, 3);
            exp_hit = m_hit(a);
            exp_d = exp_hit ? m_data[a[5:0]] : mv(a);
            fetch(a, lat, 1'b0, st, d, ok);
            checks++;
            if (!ok || st != (exp_hit ? 0 : 1 + 4 * lat) || d !== exp_d) begin
                errors++;
                $display("FAIL rand%0d addr=%h: ok=%b stalls=%0d data=%h expected 1/%0d/%h",
                         n, a, ok, st, d, exp_hit ? 0 : 1 + 4 * lat, exp_d);
            end
            if (!exp_hit) m_fill(a);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        mem_base = 16'hA000;
        test_reset();
        test_cold_miss();
        test_seq_hits();
        test_conflict();
        test_flush_idle();
        test_flush_refill();
        test_reset_mid_refill();
        test_stray();
        test_random();
        @(negedge clk);
        cpu_req = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
